mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF) and load/store (LS) requesters.
//  Sits between the fetch/LSU front ends and the unified memory controller.
//  Supports multi-cycle execution: one outstanding transaction, registered command, routed response.
//  Fixed LS priority with an IF anti-starvation counter.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  STARVE_MAX  4   consecutive LS wins while IF waits before IF is forced to win (>=1)
// PORTS
//  clk         in   1       clock; all state changes on posedge
//  rst_n       in   1       reset; one clock, asynchronous, active-low
//  if_req      in   1       IF requests a read
//  if_addr     in   ADDR_W  IF read address
//  if_gnt      out  1       IF request accepted this cycle
//  if_rvalid   out  1       IF read data valid
//  if_rdata    out  DATA_W  IF read data
//  ls_req      in   1       LS requests an access
//  ls_we       in   1       1 = store, 0 = load
//  ls_funct3   in   3       access size/sign (RV32I funct3), forwarded unchanged
//  ls_addr     in   ADDR_W  LS address
//  ls_wdata    in   DATA_W  LS store data
//  ls_gnt      out  1       LS request accepted this cycle
//  ls_rvalid   out  1       LS response (load data or store ack)
//  ls_rdata    out  DATA_W  LS load data (0 on store ack)
//  mem_req     out  1       command valid to memory
//  mem_we      out  1       command write enable
//  mem_funct3  out  3       command funct3 (3'b010 for IF)
//  mem_addr    out  ADDR_W  command address
//  mem_wdata   out  DATA_W  command write data (0 for IF)
//  mem_ready   in   1       memory accepts command while mem_req=1
//  mem_rvalid  in   1       memory response valid (reads and writes)
//  mem_rdata   in   DATA_W  memory read data
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, owner=IF, starve_cnt=0, all command regs 0; every output 0.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE; minimum 3 cycles per transaction, no overlap.
//  IDLE: winner = LS if ls_req && !(if_req && starve_cnt==STARVE_MAX), else IF if if_req.
//   Winner's gnt=1 combinationally this cycle (only in IDLE, at most one gnt high).
//   Command latched into regs and owner recorded at the edge; next state ISSUE.
//   No request: stay IDLE.
//  starve_cnt: +1 (saturating at STARVE_MAX) when LS wins while if_req=1; cleared when IF wins;
//   unchanged otherwise.
//  ISSUE: mem_req=1 with latched command; hold all mem_* stable until mem_ready=1;
//   on mem_ready -> WAIT. Requesters may change inputs freely after their gnt.
//  WAIT: mem_req=0; on mem_rvalid route to owner: <owner>_rvalid=1 (1 cycle), rdata=mem_rdata
//   (LS store: ls_rdata=0); same cycle -> IDLE. Non-owner rvalid stays 0.
//  Responses are combinational from mem_rvalid/mem_rdata gated by state==WAIT and owner.
//  mem_rvalid outside WAIT (incl. right after reset) ignored; no rvalid produced.
//  mem_ready outside ISSUE ignored.
//  Reset asserted mid-transaction: immediate return to reset values; transaction dropped, no response.
//  Address/data widths passed through unmodified; no alignment checks here.
// CONFIGURATION
//  ARB_PERF_EN defined: extra output ports perf_if_cnt, perf_ls_cnt, perf_stall_cnt (32 bits each),
//   counting IF grants, LS grants, and cycles with (if_req||ls_req) && !(if_gnt||ls_gnt);
//   wrap at 2^32, cleared by rst_n.
//  ARB_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 IF only, if_addr=0x10, mem_ready=1, mem_rvalid 1 cycle after ISSUE, rdata=0xDEADBEEF
//   -> if_gnt cycle0, mem_req cycle1, if_rvalid cycle2 with 0xDEADBEEF, ls_rvalid=0.
//  2 if_req and ls_req both held high, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS,... repeating.
//  3 LS store addr=0x200 wdata=0x12345678 funct3=3'b000, mem_ready low 3 cycles
//   -> mem_* stable for all 4 ISSUE cycles, ls_rvalid=1 with ls_rdata=0 on ack.
//  4 mem_rvalid pulsed while IDLE and while ISSUE -> no if_rvalid/ls_rvalid, state unchanged.
//  5 rst_n low during WAIT -> all outputs 0 asynchronously; later mem_rvalid ignored;
//   next if_req served normally.
//  6 ARB_PERF_EN build, scenario 2 for 20 transactions
//   -> perf_ls_cnt=16, perf_if_cnt=4, perf_stall_cnt = requesting cycles without gnt.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory between the instruction
//                fetch (IF) and load/store (LS) requesters. One outstanding
//                transaction at a time: IDLE -> ISSUE -> WAIT -> IDLE.
//                LS has fixed priority; IF is forced through after
//                STARVE_MAX consecutive LS wins while it was waiting.
//                Optional build macro ARB_PERF_EN adds 32-bit counters for
//                grants and stalled request cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store requester
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    // memory controller side
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_cnt,
    output logic [31:0]       perf_ls_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;

    localparam logic c_OWN_IF = 1'b0;
    localparam logic c_OWN_LS = 1'b1;

    // instruction fetches are always full-word reads
    localparam logic [2:0]         c_FUNCT3_WORD = 3'b010;
    localparam logic [c_CNT_W-1:0] c_STARVE_LIM  = c_CNT_W'(STARVE_MAX);

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    logic               r_owner;
    logic [c_CNT_W-1:0] r_starveCnt;
    logic               r_cmdWe;
    logic [2:0]         r_cmdFunct3;
    logic [ADDR_W-1:0]  r_cmdAddr;
    logic [DATA_W-1:0]  r_cmdWdata;

    logic w_idle;
    logic w_ifStarved;
    logic w_lsWin;
    logic w_ifWin;
    logic w_rspValid;

    // Grants are suppressed while reset is held so every output reads 0.
    assign w_idle      = (r_state == c_S_IDLE) && rst_n;
    assign w_ifStarved = if_req && (r_starveCnt == c_STARVE_LIM);
    assign w_lsWin     = w_idle && ls_req && !w_ifStarved;
    assign w_ifWin     = w_idle && if_req && !w_lsWin;

    assign if_gnt = w_ifWin;
    assign ls_gnt = w_lsWin;
    assign busy   = (r_state != c_S_IDLE);

    // The command registers drive the memory port directly so the command
    // stays stable for as long as the controller back-pressures.
    assign mem_req    = (r_state == c_S_ISSUE);
    assign mem_we     = r_cmdWe;
    assign mem_funct3 = r_cmdFunct3;
    assign mem_addr   = r_cmdAddr;
    assign mem_wdata  = r_cmdWdata;

    // Responses are only accepted while waiting; strays elsewhere are dropped.
    assign w_rspValid = (r_state == c_S_WAIT) && mem_rvalid;
    assign if_rvalid  = w_rspValid && (r_owner == c_OWN_IF);
    assign ls_rvalid  = w_rspValid && (r_owner == c_OWN_LS);
    assign if_rdata   = if_rvalid ? mem_rdata : '0;
    // a store acknowledgement carries no data
    assign ls_rdata   = (ls_rvalid && !r_cmdWe) ? mem_rdata : '0;

    // Next-state decode for the single-outstanding transaction sequence.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_IDLE:  if (w_ifWin || w_lsWin) w_nextState = c_S_ISSUE;
            c_S_ISSUE: if (mem_ready)          w_nextState = c_S_WAIT;
            c_S_WAIT:  if (mem_rvalid)         w_nextState = c_S_IDLE;
            default:                           w_nextState = c_S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Latch the winning command and its owner at the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= c_OWN_IF;
            r_cmdWe     <= 1'b0;
            r_cmdFunct3 <= 3'b000;
            r_cmdAddr   <= '0;
            r_cmdWdata  <= '0;
        end else if (w_lsWin) begin
            r_owner     <= c_OWN_LS;
            r_cmdWe     <= ls_we;
            r_cmdFunct3 <= ls_funct3;
            r_cmdAddr   <= ls_addr;
            r_cmdWdata  <= ls_wdata;
        end else if (w_ifWin) begin
            r_owner     <= c_OWN_IF;
            r_cmdWe     <= 1'b0;
            r_cmdFunct3 <= c_FUNCT3_WORD;
            r_cmdAddr   <= if_addr;
            r_cmdWdata  <= '0;
        end
    end

    // Count LS wins that left IF waiting; an IF win clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starveCnt <= '0;
        end else if (w_lsWin && if_req) begin
            if (r_starveCnt != c_STARVE_LIM) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
        end else if (w_ifWin) begin
            r_starveCnt <= '0;
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] r_perfIf;
    logic [31:0] r_perfLs;
    logic [31:0] r_perfStall;

    assign perf_if_cnt    = r_perfIf;
    assign perf_ls_cnt    = r_perfLs;
    assign perf_stall_cnt = r_perfStall;

    // Free-running grant and stall counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perfIf    <= '0;
            r_perfLs    <= '0;
            r_perfStall <= '0;
        end else begin
            if (w_ifWin) r_perfIf <= r_perfIf + 32'd1;
            if (w_lsWin) r_perfLs <= r_perfLs + 32'd1;
            if ((if_req || ls_req) && !(w_ifWin || w_lsWin)) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//                plus a randomized run checked against a transaction-level
//                reference model. Perf counters are checked when the bench is
//                built with ARB_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [2:0]        ls_funct3;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
`ifdef ARB_PERF_EN
    logic [31:0]       perf_if_cnt;
    logic [31:0]       perf_ls_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_funct3  (ls_funct3),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
`ifdef ARB_PERF_EN
        ,
        .perf_if_cnt    (perf_if_cnt),
        .perf_ls_cnt    (perf_ls_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'b000; ls_addr = '0; ls_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h44; ls_addr = 32'h88;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        #1;
        checks++;
        if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_we,
             mem_funct3, mem_addr, mem_wdata, busy} !== 138'd0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b/%b rv=%b/%b req=%b busy=%b addr=%h, need all 0",
                     if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, busy, mem_addr);
        end
        do_reset();
        #1;
        checks++;
        if ({mem_req, busy, mem_addr, mem_funct3} !== 37'd0) begin
            failures++;
            $display("FAIL reset_release: got req=%b busy=%b addr=%h f3=%b, need 0",
                     mem_req, busy, mem_addr, mem_funct3);
        end
    endtask

    task automatic test_if_single();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1;
        #1;
        checks++;
        if ({if_gnt, ls_gnt, mem_req, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL if_single_gnt: got %b, need 1000", {if_gnt, ls_gnt, mem_req, busy});
        end
        @(negedge clk);
        if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({if_gnt, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, busy} !==
            {1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL if_single_cmd: got req=%b we=%b f3=%b addr=%h wd=%h, need 1 0 010 10 0",
                     mem_req, mem_we, mem_funct3, mem_addr, mem_wdata);
        end
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({if_rvalid, if_rdata, ls_rvalid, ls_rdata, mem_req} !==
            {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL if_single_rsp: got if_rv=%b if_rd=%h ls_rv=%b, need 1 deadbeef 0",
                     if_rvalid, if_rdata, ls_rvalid);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({busy, if_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL if_single_done: got busy=%b if_rv=%b, need 0 0", busy, if_rvalid);
        end
    endtask

    // Both requesters held high: IF gets every (STARVE_MAX+1)-th slot.
    task automatic test_starvation();
        logic              expIf;
        logic [ADDR_W-1:0] aIf, aLs;
        logic [DATA_W-1:0] d;
        int nIf = 0, nLs = 0;
        do_reset();
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b100; mem_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mem_rvalid = 1'b0;
            aIf = $urandom; aLs = $urandom;
            if_addr = aIf; ls_addr = aLs;
            expIf = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
            if (expIf) nIf++; else nLs++;
            #1;
            checks++;
            if ({if_gnt, ls_gnt} !== {expIf, !expIf}) begin
                failures++;
                $display("FAIL starve_order[%0d]: got if_gnt=%b ls_gnt=%b, need %b %b",
                         k, if_gnt, ls_gnt, expIf, !expIf);
            end
            @(negedge clk);
            if_addr = $urandom; ls_addr = $urandom;
            #1;
            checks++;
            if ({mem_req, mem_funct3, mem_addr} !==
                {1'b1, (expIf ? 3'b010 : 3'b100), (expIf ? aIf : aLs)}) begin
                failures++;
                $display("FAIL starve_cmd[%0d]: got req=%b f3=%b addr=%h, need f3=%b addr=%h",
                         k, mem_req, mem_funct3, mem_addr, (expIf ? 3'b010 : 3'b100),
                         (expIf ? aIf : aLs));
            end
            @(negedge clk);
            d = $urandom;
            mem_rvalid = 1'b1; mem_rdata = d;
            #1;
            checks++;
            if ({if_rvalid, if_rdata, ls_rvalid, ls_rdata} !==
                {expIf, (expIf ? d : 32'h0), !expIf, (expIf ? 32'h0 : d)}) begin
                failures++;
                $display("FAIL starve_rsp[%0d]: got if_rv=%b ls_rv=%b if_rd=%h ls_rd=%h, owner_if=%b data=%h",
                         k, if_rvalid, ls_rvalid, if_rdata, ls_rdata, expIf, d);
            end
            @(negedge clk);
        end
`ifdef ARB_PERF_EN
        checks++;
        if ({perf_if_cnt, perf_ls_cnt, perf_stall_cnt} !== {32'(nIf), 32'(nLs), 32'd40}) begin
            failures++;
            $display("FAIL starve_perf: got if=%0d ls=%0d stall=%0d, need %0d %0d 40",
                     perf_if_cnt, perf_ls_cnt, perf_stall_cnt, nIf, nLs);
        end
`endif
        clear_inputs();
        checks++;
        if ({nIf, nLs} !== {32'd4, 32'd16}) begin
            failures++;
            $display("FAIL starve_tally: got if=%0d ls=%0d, need 4 16", nIf, nLs);
        end
    endtask

    task automatic test_store_stall();
        do_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b000;
        ls_addr = 32'h200; ls_wdata = 32'h1234_5678;
        #1;
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL store_gnt: got if=%b ls=%b, need 0 1", if_gnt, ls_gnt);
        end
        @(negedge clk);
        ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'b111; ls_addr = $urandom; ls_wdata = $urandom;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            checks++;
            if ({mem_req, mem_we, mem_funct3, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, 3'b000, 32'h200, 32'h1234_5678}) begin
                failures++;
                $display("FAIL store_hold[%0d]: got req=%b we=%b f3=%b addr=%h wd=%h, need 1 1 000 200 12345678",
                         i, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({ls_rvalid, ls_rdata, if_rvalid, mem_req} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL store_ack: got ls_rv=%b ls_rd=%h if_rv=%b, need 1 0 0",
                     ls_rvalid, ls_rdata, if_rvalid);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_spurious_rvalid();
        logic [DATA_W-1:0] d;
        do_reset();
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        #1;
        checks++;
        if ({if_rvalid, ls_rvalid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL spurious_idle: got if_rv=%b ls_rv=%b busy=%b, need 0 0 0",
                     if_rvalid, ls_rvalid, busy);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h3000;
        #1;
        checks++;
        if ({ls_gnt, busy} !== 2'b10) begin
            failures++;
            $display("FAIL spurious_gnt: got ls_gnt=%b busy=%b, need 1 0", ls_gnt, busy);
        end
        @(negedge clk);
        ls_req = 1'b0; mem_rvalid = 1'b1;
        #1;
        checks++;
        if ({if_rvalid, ls_rvalid, mem_req} !== 3'b001) begin
            failures++;
            $display("FAIL spurious_issue: got if_rv=%b ls_rv=%b req=%b, need 0 0 1",
                     if_rvalid, ls_rvalid, mem_req);
        end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h3000}) begin
            failures++;
            $display("FAIL spurious_hold: got req=%b addr=%h, need 1 3000", mem_req, mem_addr);
        end
        @(negedge clk);
        d = $urandom;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
        #1;
        checks++;
        if ({ls_rvalid, ls_rdata, if_rvalid} !== {1'b1, d, 1'b0}) begin
            failures++;
            $display("FAIL spurious_rsp: got ls_rv=%b ls_rd=%h if_rv=%b, need 1 %h 0",
                     ls_rvalid, ls_rdata, if_rvalid, d);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        do_reset();
        if_req = 1'b1; if_addr = 32'h4444; mem_ready = 1'b1;
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, mem_req} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_wait: got busy=%b req=%b, need 1 0", busy, mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_we,
             mem_funct3, mem_addr, mem_wdata, busy} !== 138'd0) begin
            failures++;
            $display("FAIL midreset_async: got busy=%b req=%b addr=%h f3=%b, need all 0",
                     busy, mem_req, mem_addr, mem_funct3);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
        #1;
        checks++;
        if ({if_rvalid, ls_rvalid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_stale: got if_rv=%b ls_rv=%b busy=%b, need 0 0 0",
                     if_rvalid, ls_rvalid, busy);
        end
        @(negedge clk);
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h5550; mem_ready = 1'b1;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midreset_regnt: got if_gnt=%b, need 1", if_gnt);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h5550}) begin
            failures++;
            $display("FAIL midreset_cmd: got req=%b addr=%h, need 1 5550", mem_req, mem_addr);
        end
        @(negedge clk);
        d = $urandom;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
        #1;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, d}) begin
            failures++;
            $display("FAIL midreset_rsp: got if_rv=%b if_rd=%h, need 1 %h", if_rvalid, if_rdata, d);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    // Randomized traffic against a transaction-level model: a transaction is
    // either pending a grant, being offered to memory, or awaiting its reply.
    task automatic test_random();
        int                phase = 0;      // 0 awaiting grant, 1 offered, 2 awaiting reply
        int                lsStreak = 0;   // LS grants since IF last got in, IF waiting
        logic              ownLs = 1'b0, xLs, xIf;
        logic              eWe = 1'b0;
        logic [2:0]        eF3 = 3'b000;
        logic [ADDR_W-1:0] eAddr = '0;
        logic [DATA_W-1:0] eWd = '0;
        int nIf = 0, nLs = 0, nStall = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
            ls_req = ($urandom_range(0, 2) != 0); ls_we = $urandom_range(0, 1);
            ls_funct3 = 3'($urandom_range(0, 7)); ls_addr = $urandom; ls_wdata = $urandom;
            mem_ready = $urandom_range(0, 1); mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            #1;
            xLs = (phase == 0) && ls_req && !(if_req && lsStreak >= STARVE_MAX);
            xIf = (phase == 0) && if_req && !xLs;
            if ((if_req || ls_req) && !(xIf || xLs)) nStall++;
            checks++;
            if ({if_gnt, ls_gnt, mem_req, busy} !== {xIf, xLs, (phase == 1), (phase != 0)}) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: got gnt=%b%b req=%b busy=%b, need %b%b %b %b",
                         c, if_gnt, ls_gnt, mem_req, busy, xIf, xLs, (phase == 1), (phase != 0));
            end
            checks++;
            if ({if_rvalid, if_rdata, ls_rvalid, ls_rdata} !==
                {(phase == 2 && mem_rvalid && !ownLs), ((phase == 2 && mem_rvalid && !ownLs) ? mem_rdata : 32'h0),
                 (phase == 2 && mem_rvalid && ownLs),
                 ((phase == 2 && mem_rvalid && ownLs && !eWe) ? mem_rdata : 32'h0)}) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: got if_rv=%b ls_rv=%b if_rd=%h ls_rd=%h phase=%0d own_ls=%b",
                         c, if_rvalid, ls_rvalid, if_rdata, ls_rdata, phase, ownLs);
            end
            if (phase == 1) begin
                checks++;
                if ({mem_we, mem_funct3, mem_addr, mem_wdata} !== {eWe, eF3, eAddr, eWd}) begin
                    failures++;
                    $display("FAIL rand_cmd[%0d]: got we=%b f3=%b addr=%h wd=%h, need %b %b %h %h",
                             c, mem_we, mem_funct3, mem_addr, mem_wdata, eWe, eF3, eAddr, eWd);
                end
            end
            case (phase)
                0: begin
                    if (xLs) begin
                        nLs++;
                        if (if_req && lsStreak < STARVE_MAX) lsStreak++;
                        ownLs = 1'b1; eWe = ls_we; eF3 = ls_funct3; eAddr = ls_addr; eWd = ls_wdata;
                        phase = 1;
                    end else if (xIf) begin
                        nIf++;
                        lsStreak = 0;
                        ownLs = 1'b0; eWe = 1'b0; eF3 = 3'b010; eAddr = if_addr; eWd = '0;
                        phase = 1;
                    end
                end
                1:       if (mem_ready)  phase = 2;
                default: if (mem_rvalid) phase = 0;
            endcase
            @(negedge clk);
        end
`ifdef ARB_PERF_EN
        checks++;
        if ({perf_if_cnt, perf_ls_cnt, perf_stall_cnt} !== {32'(nIf), 32'(nLs), 32'(nStall)}) begin
            failures++;
            $display("FAIL rand_perf: got if=%0d ls=%0d stall=%0d, need %0d %0d %0d",
                     perf_if_cnt, perf_ls_cnt, perf_stall_cnt, nIf, nLs, nStall);
        end
`endif
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_if_single();
        test_starvation();
        test_store_stall();
        test_spurious_rvalid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
